// File: rtl/weight_loader_if.sv
// Byte-stream and weight-memory write bundle for weight_loader.
// Handshake: a byte transfers on a rising edge where s_valid && s_ready; s_data is held while s_valid=1 && s_ready=0.
interface weight_loader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // master: the loader (consumes the stream, drives the memory write port)
    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/weight_loader.sv
// Loads a sync-prefixed, checksummed byte frame into the weight memory from address 0.
// Optional idle timeout is compiled in with the macro WEIGHT_LOADER_TIMEOUT_EN.
module weight_loader #(
    parameter int                DEPTH     = 7840,
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
    parameter int                TIMEOUT   = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    weight_loader_if.master bus,
    output logic           busy,
    output logic           weights_valid,
    output logic           error,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SYNC = 3'd1,
        S_LOAD      = 3'd2,
        S_CHECK     = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("weight_loader: ADDR_W too narrow for DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("weight_loader: TIMEOUT must be at least 1");
    end

    state_t            state;
    state_t            state_next;
    logic              active;
    logic              accept;
    logic              last_byte;
    logic              timeout_hit;
    logic              enter_sync;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] acc;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign accept     = bus.s_valid && active;
    assign last_byte  = (cnt == ADDR_W'(DEPTH - 1));
    assign enter_sync = (state_next == S_WAIT_SYNC) && (state != S_WAIT_SYNC);

`ifdef WEIGHT_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = active && !accept && (idle_cnt == TO_W'(TIMEOUT - 1));

    // Restarts on every accepted byte and on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!active || accept || (state_next != state)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured when not busy
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                if (accept && (bus.s_data == SYNC_BYTE)) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (accept && last_byte) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_next = (bus.s_data == acc) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_ERR;
    end

    // Outputs decoded from state, so busy and the flags can never overlap
    always_comb begin
        active        = 1'b0;
        busy          = 1'b0;
        weights_valid = 1'b0;
        error         = 1'b0;
        unique case (state)
            S_WAIT_SYNC, S_LOAD, S_CHECK: begin
                active = 1'b1;
                busy   = 1'b1;
            end
            S_DONE:  weights_valid = 1'b1;
            S_ERR:   error = 1'b1;
            default: ;
        endcase
    end

    // Byte counter, checksum and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if ((state == S_IDLE) || enter_sync) begin
                cnt <= '0;
                acc <= '0;
            end else if ((state == S_LOAD) && accept) begin
                acc       <= acc + bus.s_data;
                wr_en_q   <= 1'b1;
                wr_addr_q <= cnt;
                wr_data_q <= bus.s_data;
                // Parks on the last address so wr_addr never wraps
                if (!last_byte) cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    assign bus.s_ready = active;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a DEPTH=16 instance for frame/error/reset/timeout cases and a full-size instance.
module tb_weight_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start16 = 1'b0;
    logic       startb = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       sel = 1'b0;

    logic       busy16, wv16, err16, busyb, wvb, errb;
    logic [2:0] st16, stb;
    logic       cur_ready;

    int n_checks = 0;
    int n_fail = 0;
    int n_wr16 = 0;
    int big_cnt = 0;
    logic [12:0] big_last_addr = '0;
    logic [7:0]  big_last_data = '0;
    logic [20:0] exp_q[$];

    weight_loader_if #(.ADDR_W(13), .DATA_W(8)) if16 ();
    weight_loader_if #(.ADDR_W(13), .DATA_W(8)) ifbig ();

    assign if16.s_valid  = s_valid && !sel;
    assign if16.s_data   = s_data;
    assign ifbig.s_valid = s_valid && sel;
    assign ifbig.s_data  = s_data;
    assign cur_ready     = sel ? ifbig.s_ready : if16.s_ready;

    weight_loader #(.DEPTH(16), .ADDR_W(13), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(100)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bus(if16.master),
        .busy(busy16), .weights_valid(wv16), .error(err16), .state_dbg(st16)
    );

    weight_loader #(.DEPTH(7840), .ADDR_W(13), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(65535)) ubig (
        .clk(clk), .rst_n(rst_n), .start(startb), .bus(ifbig.master),
        .busy(busyb), .weights_valid(wvb), .error(errb), .state_dbg(stb)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // scoreboard for the small instance; 1FFFFF marks a write nobody expected
    always @(negedge clk) begin
        logic [20:0] exp_w;
        if (if16.wr_en === 1'b1) begin
            n_wr16++;
            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            else exp_w = 21'h1FFFFF;
            check("wr16_addr_data", {11'd0, if16.wr_addr, if16.wr_data}, {11'd0, exp_w});
        end
        if (ifbig.wr_en === 1'b1) begin
            check("big_addr", 32'(ifbig.wr_addr), 32'(big_cnt));
            check("big_data", 32'(ifbig.wr_data), 32'(big_cnt % 256));
            big_last_addr = ifbig.wr_addr;
            big_last_data = ifbig.wr_data;
            big_cnt++;
        end
    end

    // driver tasks; all called and returning on a falling edge
    task automatic send_byte(input logic [7:0] b, input bit pay);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!cur_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("handshake_wait", 32'(cur_ready), 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (pay && !sel) check("wr16_latency", 32'(if16.wr_en), 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start16();
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic push_exp16();
        for (int i = 0; i < 16; i++) exp_q.push_back({13'(i), 8'(i)});
    endtask

    task automatic send_frame16(input logic [7:0] chk);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        send_byte(chk, 1'b0);
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(if16.s_ready), 32'd0);
        check("rst_wr_en", 32'(if16.wr_en), 32'd0);
        check("rst_wr_addr", 32'(if16.wr_addr), 32'd0);
        check("rst_wr_data", 32'(if16.wr_data), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_valid", 32'(wv16), 32'd0);
        check("rst_error", 32'(err16), 32'd0);
        check("rst_state", 32'(st16), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // good frame, back-to-back bytes
        check("idle_ready", 32'(if16.s_ready), 32'd0);
        pulse_start16();
        check("armed_busy", 32'(busy16), 32'd1);
        check("armed_ready", 32'(if16.s_ready), 32'd1);
        n_wr16 = 0;
        push_exp16();
        send_frame16(8'h78);
        check("good_valid", 32'(wv16), 32'd1);
        check("good_error", 32'(err16), 32'd0);
        check("good_busy", 32'(busy16), 32'd0);
        check("good_ready", 32'(if16.s_ready), 32'd0);
        check("good_nwr", 32'(n_wr16), 32'd16);
        check("good_q_empty", 32'(exp_q.size()), 32'd0);

        // junk before sync, wrong checksum
        pulse_start16();
        check("restart_valid_clr", 32'(wv16), 32'd0);
        n_wr16 = 0;
        send_byte(8'h3C, 1'b0);
        send_byte(8'h11, 1'b0);
        check("junk_no_write", 32'(n_wr16), 32'd0);
        push_exp16();
        send_frame16(8'h77);
        check("bad_error", 32'(err16), 32'd1);
        check("bad_valid", 32'(wv16), 32'd0);
        check("bad_busy", 32'(busy16), 32'd0);
        check("bad_nwr", 32'(n_wr16), 32'd16);
        pulse_start16();
        check("restart_error_clr", 32'(err16), 32'd0);
        check("restart_busy", 32'(busy16), 32'd1);
        push_exp16();
        send_frame16(8'h78);
        check("retry_valid", 32'(wv16), 32'd1);
        check("retry_error", 32'(err16), 32'd0);

        // gaps and start pulses while loading
        pulse_start16();
        n_wr16 = 0;
        push_exp16();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 4) begin
                s_valid = 1'b0;
                pulse_start16();
            end
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) start16 = 1'b1;
                @(negedge clk);
                start16 = 1'b0;
            end
            if (i < 15) check("gap_busy", 32'(busy16), 32'd1);
        end
        send_byte(8'h78, 1'b0);
        s_valid = 1'b0;
        check("gap_valid", 32'(wv16), 32'd1);
        check("gap_nwr", 32'(n_wr16), 32'd16);
        check("gap_q_empty", 32'(exp_q.size()), 32'd0);

        // full-size frame
        sel = 1'b1;
        startb = 1'b1;
        @(negedge clk);
        startb = 1'b0;
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 7840; i++) send_byte(8'(i % 256), 1'b0);
        send_byte(8'hB0, 1'b0);
        s_valid = 1'b0;
        check("big_valid", 32'(wvb), 32'd1);
        check("big_error", 32'(errb), 32'd0);
        check("big_nwr", 32'(big_cnt), 32'd7840);
        check("big_last_addr", 32'(big_last_addr), 32'd7839);
        check("big_last_data", 32'(big_last_data), 32'h9F);
        sel = 1'b0;

        // reset in the middle of a frame
        pulse_start16();
        push_exp16();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(if16.wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(if16.wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(if16.wr_data), 32'd0);
        check("mid_rst_busy", 32'(busy16), 32'd0);
        check("mid_rst_ready", 32'(if16.s_ready), 32'd0);
        check("mid_rst_valid", 32'(wv16), 32'd0);
        check("mid_rst_error", 32'(err16), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start16();
        n_wr16 = 0;
        push_exp16();
        send_frame16(8'h78);
        check("post_rst_valid", 32'(wv16), 32'd1);
        check("post_rst_nwr", 32'(n_wr16), 32'd16);

`ifdef WEIGHT_LOADER_TIMEOUT_EN
        // stall of exactly TIMEOUT cycles
        pulse_start16();
        for (int i = 0; i < 3; i++) exp_q.push_back({13'(i), 8'(i)});
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b1);
        idle(99);
        check("to_99_busy", 32'(busy16), 32'd1);
        idle(1);
        check("to_error", 32'(err16), 32'd1);
        check("to_ready", 32'(if16.s_ready), 32'd0);
        check("to_busy", 32'(busy16), 32'd0);
        check("to_valid", 32'(wv16), 32'd0);
        check("to_q_empty", 32'(exp_q.size()), 32'd0);

        // stall of TIMEOUT-1 cycles survives
        pulse_start16();
        push_exp16();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b1);
        idle(99);
        for (int i = 3; i < 16; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h78, 1'b0);
        s_valid = 1'b0;
        check("stall99_valid", 32'(wv16), 32'd1);
        check("stall99_error", 32'(err16), 32'd0);
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
